intr_ctrl: RTL and testbench

Interrupt controller for the 32 kHz always-on domain. It collects one-cycle event flags from the FIFO, sampling, LDO, circuit-monitor and user logic, plus an internal periodic timer, into a sticky, maskable status vector. It drives a single external INT pin with programmable polarity, pulse/level mode, pulse width, cold (hold-off) time and optional deferral until the end of a frame.

---
 rtl/intr_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_intr_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Interrupt controller for the 32 kHz always-on domain: sticky maskable status vector,
// a programmable INT pin (polarity, pulse/level, width, hold-off, frame deferral) and a periodic timer.
module intr_ctrl #(
    parameter int NW = 11
) (
    input  logic          clk_32k,
    input  logic          rst,
    input  logic [NW-1:0] rg_int_enable,
    input  logic [NW-1:0] rg_int_clr,
    input  logic          rg_int_low_en,
    input  logic          rg_int_level_en,
    input  logic [10:0]   rg_int_width,
    input  logic [5:0]    rg_cold_time,
    input  logic          rg_int_after_frame,
    input  logic          rg_timer_on,
    input  logic          rg_timer_mode,
    input  logic [8:0]    rg_timer_sel,
    input  logic          frame_on,
    input  logic          fifo_upov_flag,
    input  logic          fifo_downov_flag,
    input  logic          fifo_waterline_flag,
    input  logic          user_int_triger,
    input  logic          frame_done_flag,
    input  logic          sample_err_flag,
    input  logic          cap_cancel_done_flag,
    input  logic          ldo_ov_flag,
    input  logic          circuit_exc_flag,
    output logic [NW-1:0] int_status,
    output logic          int_out
);

    // One timer unit is 0.2 s of the 32.768 kHz clock.
    localparam logic [20:0] TICK_UNIT = 21'd6554;
    localparam logic [8:0]  SEL_MAX   = 9'd300;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_COLD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [10:0]   cnt;
    logic [10:0]   cnt_nxt;
    logic          pend;
    logic          pend_nxt;
    logic          start_pulse;
    logic          gate;
    logic          asserted;

    logic [NW-1:0] src;
    logic [NW-1:0] raw;
    logic [NW-1:0] status_nxt;

    logic [8:0]    sel_eff;
    logic [20:0]   tmr_period;
    logic [20:0]   tmr_cnt;
    logic          tmr_done;
    logic          tmr_tc;

    // ------------------------------------------------------------------
    // Periodic timer
    // ------------------------------------------------------------------
    always_comb begin
        if (rg_timer_sel == 9'd0) begin
            sel_eff = 9'd1;
        end else if (rg_timer_sel > SEL_MAX) begin
            sel_eff = SEL_MAX;
        end else begin
            sel_eff = rg_timer_sel;
        end
    end

    assign tmr_period = 21'(sel_eff) * TICK_UNIT;
    // >= rather than == so a period shortened mid-count still terminates.
    assign tmr_tc     = rg_timer_on & ~tmr_done & (tmr_cnt >= tmr_period - 21'd1);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk_32k) begin
        if (rst || !rg_timer_on) begin
            tmr_cnt  <= '0;
            tmr_done <= 1'b0;
        end else if (tmr_tc) begin
            tmr_cnt  <= '0;
            tmr_done <= ~rg_timer_mode;
        end else if (!tmr_done) begin
            tmr_cnt  <= tmr_cnt + 21'd1;
        end
    end

    // ------------------------------------------------------------------
    // Source collection and sticky status
    // ------------------------------------------------------------------
    always_comb begin
        src     = '0;
        src[0]  = user_int_triger;
        src[1]  = fifo_upov_flag;
        src[2]  = fifo_downov_flag;
        src[3]  = fifo_waterline_flag;
        src[4]  = frame_done_flag;
        src[5]  = sample_err_flag;
        src[6]  = cap_cancel_done_flag;
        src[7]  = ldo_ov_flag;
        src[8]  = circuit_exc_flag;
        src[9]  = tmr_tc;
    end

    assign raw        = src & rg_int_enable;
    // A set in the same cycle as its clear wins.
    assign status_nxt = (int_status & ~rg_int_clr) | raw;

    assign gate = ~(rg_int_after_frame & frame_on);

    // ------------------------------------------------------------------
    // Pulse-mode FSM
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        start_pulse = 1'b0;
        if (rg_int_level_en) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pend && gate) begin
                        state_nxt   = ST_PULSE;
                        cnt_nxt     = rg_int_width;
                        start_pulse = 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        state_nxt = ST_COLD;
                        cnt_nxt   = {rg_cold_time, 5'h1f};   // (cold+1)*32-1
                    end else begin
                        cnt_nxt = cnt - 11'd1;
                    end
                end
                ST_COLD: begin
                    if (cnt == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt - 11'd1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // New events win over the clear on pulse entry; an empty status drops the request.
    assign pend_nxt = (|raw | (pend & ~start_pulse)) & (|status_nxt);

    always_ff @(posedge clk_32k) begin
        if (rst) begin
            int_status <= '0;
            state      <= ST_IDLE;
            cnt        <= '0;
            pend       <= 1'b0;
        end else begin
            int_status <= status_nxt;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pend       <= pend_nxt;
        end
    end

    // ------------------------------------------------------------------
    // INT pin: mode and polarity act combinationally
    // ------------------------------------------------------------------
    assign asserted = rg_int_level_en ? ((|int_status) & gate) : (state == ST_PULSE);
    assign int_out  = asserted ^ rg_int_low_en;

endmodule

// File: tb/tb_intr_ctrl.sv
// Randomized and directed bench for intr_ctrl: a timeline reference model feeds a
// scoreboard queue, and a negedge monitor compares every cycle.
module tb_intr_ctrl;

    localparam int NW = 11;

    logic          clk_32k = 1'b0;
    logic          rst;
    logic [NW-1:0] rg_int_enable;
    logic [NW-1:0] rg_int_clr;
    logic          rg_int_low_en;
    logic          rg_int_level_en;
    logic [10:0]   rg_int_width;
    logic [5:0]    rg_cold_time;
    logic          rg_int_after_frame;
    logic          rg_timer_on;
    logic          rg_timer_mode;
    logic [8:0]    rg_timer_sel;
    logic          frame_on;
    logic          fifo_upov_flag;
    logic          fifo_downov_flag;
    logic          fifo_waterline_flag;
    logic          user_int_triger;
    logic          frame_done_flag;
    logic          sample_err_flag;
    logic          cap_cancel_done_flag;
    logic          ldo_ov_flag;
    logic          circuit_exc_flag;
    logic [NW-1:0] int_status;
    logic          int_out;

    always #5 clk_32k = ~clk_32k;

    intr_ctrl #(.NW(NW)) dut (
        .clk_32k              (clk_32k),
        .rst                  (rst),
        .rg_int_enable        (rg_int_enable),
        .rg_int_clr           (rg_int_clr),
        .rg_int_low_en        (rg_int_low_en),
        .rg_int_level_en      (rg_int_level_en),
        .rg_int_width         (rg_int_width),
        .rg_cold_time         (rg_cold_time),
        .rg_int_after_frame   (rg_int_after_frame),
        .rg_timer_on          (rg_timer_on),
        .rg_timer_mode        (rg_timer_mode),
        .rg_timer_sel         (rg_timer_sel),
        .frame_on             (frame_on),
        .fifo_upov_flag       (fifo_upov_flag),
        .fifo_downov_flag     (fifo_downov_flag),
        .fifo_waterline_flag  (fifo_waterline_flag),
        .user_int_triger      (user_int_triger),
        .frame_done_flag      (frame_done_flag),
        .sample_err_flag      (sample_err_flag),
        .cap_cancel_done_flag (cap_cancel_done_flag),
        .ldo_ov_flag          (ldo_ov_flag),
        .circuit_exc_flag     (circuit_exc_flag),
        .int_status           (int_status),
        .int_out              (int_out)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: status as a set, the INT pin as time windows.
    // Cycle k is the interval following clock edge k.
    // ------------------------------------------------------------------
    typedef struct {
        logic [NW-1:0] exp_status;
        logic          exp_int;
    } exp_t;

    exp_t          sb_q[$];
    logic [NW-1:0] m_status;
    bit            m_pend;
    longint        m_cyc = 0;
    longint        m_p_start, m_p_end, m_c_end;   // pulse window and end of hold-off
    longint        m_tmr_el;                      // edges seen with the timer on

    task automatic model_step();
        logic [NW-1:0] src;
        logic [NW-1:0] raw;
        logic [NW-1:0] nxt;
        longint        k;
        int            sel_eff;
        int            per;
        bit            tmr_evt;
        bit            gate;
        bit            start;
        bit            idle_prev;
        m_cyc++;
        k = m_cyc;
        if (rst) begin
            m_status  = '0;
            m_pend    = 1'b0;
            m_p_start = k;
            m_p_end   = k - 1;
            m_c_end   = k - 1;
            m_tmr_el  = 0;
            return;
        end
        tmr_evt = 1'b0;
        if (!rg_timer_on) begin
            m_tmr_el = 0;
        end else begin
            sel_eff = (rg_timer_sel == 0) ? 1 : ((rg_timer_sel > 300) ? 300 : int'(rg_timer_sel));
            per = 6554 * sel_eff;
            m_tmr_el++;
            tmr_evt = rg_timer_mode ? (m_tmr_el % per == 0) : (m_tmr_el == per);
        end
        src = '0;
        src[0] = user_int_triger;
        src[1] = fifo_upov_flag;
        src[2] = fifo_downov_flag;
        src[3] = fifo_waterline_flag;
        src[4] = frame_done_flag;
        src[5] = sample_err_flag;
        src[6] = cap_cancel_done_flag;
        src[7] = ldo_ov_flag;
        src[8] = circuit_exc_flag;
        src[9] = tmr_evt;
        raw  = src & rg_int_enable;
        nxt  = (m_status & ~rg_int_clr) | raw;
        gate = !(rg_int_after_frame && frame_on);

        start     = 1'b0;
        idle_prev = (k - 1 > m_c_end) && (k - 1 > m_p_end);
        if (rg_int_level_en) begin
            m_p_start = k;
            m_p_end   = k - 1;
            m_c_end   = k - 1;
        end else if (idle_prev && m_pend && gate) begin
            start     = 1'b1;
            m_p_start = k;
            m_p_end   = k + longint'(rg_int_width);
            m_c_end   = m_p_end;
        end else if (k - 1 == m_p_end && m_c_end == m_p_end) begin
            m_c_end = k + (longint'(rg_cold_time) + 1) * 32 - 1;
        end

        if (start) m_pend = 1'b0;
        if (raw != 0) m_pend = 1'b1;
        if (nxt == 0) m_pend = 1'b0;
        m_status = nxt;
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        bit   gate_now;
        bit   asserted;
        gate_now = !(rg_int_after_frame && frame_on);
        if (rg_int_level_en) asserted = (m_status != 0) && gate_now;
        else asserted = (m_cyc >= m_p_start) && (m_cyc <= m_p_end);
        e.exp_status = m_status;
        e.exp_int    = asserted ^ rg_int_low_en;
        return e;
    endfunction

    // Push the expectation for the current cycle, then advance one edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(expect_now());
            @(posedge clk_32k);
            model_step();
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: scoreboard comparison plus pulse/timer bookkeeping
    // ------------------------------------------------------------------
    longint rise_cyc[$];
    longint fall_cyc[$];
    int     tmr_hits = 0;

    initial begin
        exp_t   e;
        longint mon_cyc;
        logic   act;
        logic   prev_act;
        mon_cyc  = 0;
        prev_act = 1'b0;
        forever begin
            @(negedge clk_32k);
            mon_cyc++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("int_status", 32'(int_status), 32'(e.exp_status));
                check("int_out", 32'(int_out), 32'(e.exp_int));
            end
            act = int_out ^ rg_int_low_en;
            if (act === 1'b1 && prev_act !== 1'b1) rise_cyc.push_back(mon_cyc);
            if (act !== 1'b1 && prev_act === 1'b1) fall_cyc.push_back(mon_cyc);
            prev_act = act;
            if (int_status[9] === 1'b1) tmr_hits++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int r0;
        int f0;
        int t0;
        rst = 1'b1;
        rg_int_enable = '0;  rg_int_clr = '0;
        rg_int_low_en = 1'b1; rg_int_level_en = 1'b0;
        rg_int_width = '0;   rg_cold_time = '0;
        rg_int_after_frame = 1'b0; frame_on = 1'b0;
        rg_timer_on = 1'b0;  rg_timer_mode = 1'b0; rg_timer_sel = '0;
        fifo_upov_flag = 0; fifo_downov_flag = 0; fifo_waterline_flag = 0;
        user_int_triger = 0; frame_done_flag = 0; sample_err_flag = 0;
        cap_cancel_done_flag = 0; ldo_ov_flag = 0; circuit_exc_flag = 0;

        @(posedge clk_32k);
        model_step();
        #1;
        step(3);
        #2;
        check("reset_status", 32'(int_status), 32'h0);
        check("reset_int_inactive_low_en", 32'(int_out), 32'h1);

        // Single pulse, 640 cycles wide, no repeat.
        rst = 1'b0; rg_int_low_en = 1'b0;
        rg_int_enable = 11'h001; rg_int_width = 11'h27f; rg_cold_time = 6'h13;
        step(2);
        r0 = rise_cyc.size(); f0 = fall_cyc.size();
        user_int_triger = 1'b1; step(1); user_int_triger = 1'b0;
        #2;
        check("t1_status", 32'(int_status), 32'h001);
        step(1500);
        check("t1_pulse_count", 32'(rise_cyc.size() - r0), 32'd1);
        if (rise_cyc.size() > r0 && fall_cyc.size() > f0)
            check("t1_pulse_width", 32'(fall_cyc[f0] - rise_cyc[r0]), 32'd640);

        // Second event during PULSE is deferred past COLD and one IDLE cycle.
        rg_int_enable = 11'h7ff;
        r0 = rise_cyc.size(); f0 = fall_cyc.size();
        user_int_triger = 1'b1; step(1); user_int_triger = 1'b0;
        step(99);
        sample_err_flag = 1'b1; step(1); sample_err_flag = 1'b0;
        step(2700);
        check("t2_status", 32'(int_status), 32'h021);
        check("t2_pulse_count", 32'(rise_cyc.size() - r0), 32'd2);
        if (rise_cyc.size() >= r0 + 2 && fall_cyc.size() >= f0 + 2) begin
            check("t2_first_width", 32'(fall_cyc[f0] - rise_cyc[r0]), 32'd640);
            check("t2_gap", 32'(rise_cyc[r0+1] - fall_cyc[f0]), 32'((6'h13 + 1) * 32 + 1));
            check("t2_second_width", 32'(fall_cyc[f0+1] - rise_cyc[r0+1]), 32'd640);
        end

        // Write-1-to-clear on an unset bit, then everything.
        rg_int_clr = 11'h100; step(1); rg_int_clr = '0;
        #2;
        check("t3_clr_unset", 32'(int_status), 32'h021);
        rg_int_clr = 11'h7ff; step(1); rg_int_clr = '0;
        #2;
        check("t3_clr_all", 32'(int_status), 32'h000);

        // Disabled source is ignored.
        rg_int_enable = 11'h001;
        step(2);
        r0 = rise_cyc.size();
        sample_err_flag = 1'b1; step(1); sample_err_flag = 1'b0;
        step(50);
        check("t4_masked_status", 32'(int_status), 32'h000);
        check("t4_masked_no_pulse", 32'(rise_cyc.size() - r0), 32'd0);

        // Level mode, active low, deferred by frame.
        rg_int_level_en = 1'b1; rg_int_low_en = 1'b1;
        rg_int_after_frame = 1'b1; frame_on = 1'b1;
        step(2);
        user_int_triger = 1'b1; step(1); user_int_triger = 1'b0;
        #2;
        check("t5_status", 32'(int_status), 32'h001);
        check("t5_held_by_frame", 32'(int_out), 32'h1);
        step(5);
        frame_on = 1'b0;
        #2;
        check("t5_frame_drop", 32'(int_out), 32'h0);
        step(5);
        rg_int_clr = 11'h001; step(1); rg_int_clr = '0;
        #2;
        check("t5_after_clear", 32'(int_out), 32'h1);
        step(2);
        rg_int_level_en = 1'b0; rg_int_low_en = 1'b0; rg_int_after_frame = 1'b0;
        step(2);

        // Timer, auto reload: bit 9 held under clear so each event shows for one cycle.
        rg_int_enable = 11'h200; rg_int_clr = 11'h200;
        rg_timer_sel = 9'd1; rg_timer_mode = 1'b1; rg_timer_on = 1'b1;
        t0 = tmr_hits;
        step(3 * 6554 + 5);
        check("t6_auto_events", 32'(tmr_hits - t0), 32'd3);
        rg_timer_on = 1'b0; step(2);

        // Single shot with sel=0 (treated as 1).
        rg_timer_mode = 1'b0; rg_timer_sel = 9'd0; rg_timer_on = 1'b1;
        t0 = tmr_hits;
        step(3 * 6554 + 5);
        check("t6_single_events", 32'(tmr_hits - t0), 32'd1);
        rg_timer_on = 1'b0; rg_int_clr = '0;
        step(2);

        // Randomized traffic with short widths, mode/polarity/frame changes and resets.
        rg_int_width = 11'd3; rg_cold_time = 6'd0; rg_int_enable = 11'h7ff;
        for (int i = 0; i < 6000; i++) begin
            user_int_triger      = ($urandom_range(0, 39) == 0);
            fifo_upov_flag       = ($urandom_range(0, 39) == 0);
            fifo_downov_flag     = ($urandom_range(0, 39) == 0);
            fifo_waterline_flag  = ($urandom_range(0, 39) == 0);
            frame_done_flag      = ($urandom_range(0, 39) == 0);
            sample_err_flag      = ($urandom_range(0, 39) == 0);
            cap_cancel_done_flag = ($urandom_range(0, 39) == 0);
            ldo_ov_flag          = ($urandom_range(0, 39) == 0);
            circuit_exc_flag     = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 63) == 0) rg_int_enable = 11'($urandom);
            rg_int_clr = ($urandom_range(0, 15) == 0) ? 11'($urandom) : '0;
            if ($urandom_range(0, 199) == 0) rg_int_level_en = ~rg_int_level_en;
            if ($urandom_range(0, 299) == 0) rg_int_low_en = ~rg_int_low_en;
            if ($urandom_range(0, 99) == 0) rg_int_after_frame = 1'($urandom);
            if ($urandom_range(0, 29) == 0) frame_on = ~frame_on;
            if ($urandom_range(0, 49) == 0) begin
                rg_int_width = 11'($urandom_range(0, 12));
                rg_cold_time = 6'($urandom_range(0, 1));
            end
            rst = ($urandom_range(0, 999) == 0);
            step(1);
        end

        rst = 1'b0;
        user_int_triger = 0; fifo_upov_flag = 0; fifo_downov_flag = 0; fifo_waterline_flag = 0;
        frame_done_flag = 0; sample_err_flag = 0; cap_cancel_done_flag = 0;
        ldo_ov_flag = 0; circuit_exc_flag = 0; rg_int_clr = '0;
        step(4);
        @(negedge clk_32k);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
